muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative 32-bit multiply/divide engine with the architectural HI/LO registers, fed by the
//  execute stage of the pipelined MIPS32 core (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
//  Runs one radix-2 step per clock, reports busy so hazard logic stalls MFHI/MFLO and new
//  mul/div ops, and pulses done when HI/LO are updated.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous active-high reset
//  start      in   1      launch op (execute-stage muldiv enable, already qualified by stall)
//  op_div     in   1      0 = multiply, 1 = divide
//  op_signed  in   1      1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU)
//  a          in   WIDTH  rs operand: multiplicand / dividend
//  b          in   WIDTH  rt operand: multiplier / divisor
//  abort      in   1      pipeline flush: cancel in-flight op
//  hi_we      in   1      MTHI write strobe
//  lo_we      in   1      MTLO write strobe
//  wd         in   WIDTH  MTHI/MTLO write data
//  busy       out  1      op in progress; hazard unit stalls dependent instructions
//  done       out  1      one-cycle pulse: HI/LO updated with result this cycle
//  hi         out  WIDTH  HI register (product upper / remainder)
//  lo         out  WIDTH  LO register (product lower / quotient)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//  States: IDLE -> CALC -> FIX -> IDLE.
//   IDLE: start=1 at edge E0 -> latch magnitudes of a/b (two's-complement abs if op_signed),
//         result signs, op_div; counter=WIDTH; go CALC. busy=1 from E0.
//   CALC: one shift-add (mul) or restoring shift-subtract (div) step per edge; counter--;
//         after WIDTH steps (edges E1..E32 for WIDTH=32) go FIX.
//   FIX : at edge E33 write hi/lo with sign fix-up; done=1 and busy=0 for cycle after E33;
//         go IDLE. Latency start->done = WIDTH+1 edges; new start accepted on done cycle.
//  Sign rules (op_signed=1): product negated if signs of a,b differ; quotient negated if signs
//   differ; remainder takes sign of dividend. 0x80000000/-1 -> lo=0x80000000, hi=0.
//  Divide by zero (b=0): no exception; hi=a, lo={WIDTH{1'b1}}; same latency, same done pulse.
//  start while busy: ignored; running op unaffected.
//  abort while busy: next edge -> IDLE, busy=0, done=0, hi/lo keep pre-op values.
//   abort in IDLE: no effect. abort and start same edge in IDLE: start ignored.
//  hi_we/lo_we: honoured only in IDLE and with start=0; register updates at next edge.
//   Ignored while busy or when start=1 same edge (start wins). hi_we+lo_we together allowed.
//  HI/LO never change except at FIX, MTHI/MTLO, or reset; outputs registered, no comb path
//   from inputs to busy/done/hi/lo.
// TESTING
//  T1 unsigned mul a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 33 edges after start;
//     hi=0xFFFFFFFE lo=0x00000001; busy high 33 cycles.
//  T2 signed mul a=-3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; signed div a=-7 b=2 ->
//     lo=0xFFFFFFFD hi=0xFFFFFFFF; unsigned div 100/7 -> lo=14 hi=2.
//  T3 div by zero a=5 b=0 -> hi=5 lo=0xFFFFFFFF, done after 33 edges; signed
//     0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  T4 MTHI wd=0x1234, MTLO wd=0x5678 in IDLE -> hi=0x1234 lo=0x5678; then start
//     mul 6*7, abort on 10th busy cycle -> busy=0 next edge, hi/lo still 0x1234/0x5678.
//  T5 during busy: second start (9*9) and hi_we wd=0xDEAD -> both ignored; first op
//     (6*7) completes hi=0 lo=42; back-to-back start on done cycle accepted.
//  T6 assert rst mid-CALC (between edges) -> hi=lo=0, busy=done=0 immediately; after
//     release, 2*3 completes normally lo=6.

Source files
------------

// File: rtl/muldiv_if.sv
// Execute-stage to mul/div engine bundle: op launch, flush, MTHI/MTLO writes and HI/LO results.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             abort;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op_div, op_signed, a, b, abort, hi_we, lo_we, wd,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op_div, op_signed, a, b, abort, hi_we, lo_we, wd,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide with architectural HI/LO; start->done is WIDTH+1 edges.
// Busy stalls dependents; new starts are ignored while busy, abort cancels without touching HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_p;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_m;
  logic             r_div;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;

  assign w_a_neg = bus.op_signed & bus.a[WIDTH-1];
  assign w_b_neg = bus.op_signed & bus.b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~bus.a + 1'b1) : bus.a;
  assign w_b_mag = w_b_neg ? (~bus.b + 1'b1) : bus.b;

  // Multiply: {r_p, r_q} is the product shifting right, r_q's low bit selects the add.
  assign w_sum = {1'b0, r_p} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

  // Divide: r_p is the partial remainder, r_q shifts dividend bits out and quotient bits in.
  assign w_rem_sh = {r_p, r_q[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_m});
  assign w_diff   = w_rem_sh - {1'b0, r_m};

  assign w_prod = r_neg_q ? (~{r_p, r_q} + 1'b1) : {r_p, r_q};
  // Divide by zero leaves all-ones quotient regardless of operand signs.
  assign w_quo  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? (~r_q + 1'b1) : r_q);
  assign w_rem  = r_neg_r ? (~r_p + 1'b1) : r_p;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_p     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_p     <= '0;
            r_q     <= w_a_mag;
            r_m     <= w_b_mag;
            r_div   <= bus.op_div;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dz    <= bus.op_div && (bus.b == '0);
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else if (!bus.start) begin
            if (bus.hi_we) r_hi <= bus.wd;
            if (bus.lo_we) r_lo <= bus.wd;
          end
        end
        S_CALC: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            if (r_div) begin
              r_p <= w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
              r_q <= {r_q[WIDTH-2:0], w_ge};
            end else begin
              r_p <= w_sum[WIDTH:1];
              r_q <= {w_sum[0], r_q[WIDTH-1:1]};
            end
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CW'(1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (!bus.abort) begin
            r_done <= 1'b1;
            if (r_div) begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an arithmetic model,
// and hand sequences for abort, ignored start/MTHI while busy, back-to-back start and async reset.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit          dv;
    bit          sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Arithmetic reference: 64-bit math, SV division truncates toward zero.
  task automatic ref_model(input bit dv, input bit sg, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] hi, output logic [31:0] lo);
    longint p, q, r;
    if (!dv) begin
      if (sg) p = longint'($signed(a)) * longint'($signed(b));
      else    p = longint'({32'b0, a}) * longint'({32'b0, b});
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      if (sg) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
      end else begin
        q = longint'({32'b0, a}) / longint'({32'b0, b});
        r = longint'({32'b0, a}) % longint'({32'b0, b});
      end
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  // Called 1 time unit after an edge with the unit idle; returns on the done cycle (or timeout).
  task automatic run_op(input bit dv, input bit sg, input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output int bcnt);
    bus.start = 1'b1; bus.op_div = dv; bus.op_signed = sg; bus.a = av; bus.b = bv;
    lat = 99; bcnt = 0;
    @(posedge clk); #1 bus.start = 1'b0;
    if (bus.busy) bcnt++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.busy) bcnt++;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t vecs[8];
  logic [31:0] ehi, elo;
  int lat, bcnt, dcnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1000000");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{0, 1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{1, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{1, 0, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{1, 0, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
    vecs[5] = '{1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[6] = '{1, 1, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[7] = '{1, 1, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    bus.start = 0; bus.op_div = 0; bus.op_signed = 0; bus.a = 0; bus.b = 0;
    bus.abort = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wd = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", bus.hi, 0);
    chk("reset_lo", bus.lo, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].dv, vecs[i].sg, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("vec%0d_lat", i), lat, 33);
      chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
      chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
      if (i == 0) chk("vec0_busy_cycles", bcnt, 33);
    end

    for (int i = 0; i < 30; i++) begin
      bit dv, sg;
      logic [31:0] av, bv;
      dv = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      av = $urandom;
      bv = $urandom;
      if ($urandom_range(0, 7) == 0) bv = 0;
      else if ($urandom_range(0, 3) == 0) bv = $urandom_range(1, 15);
      ref_model(dv, sg, av, bv, ehi, elo);
      run_op(dv, sg, av, bv, lat, bcnt);
      chk($sformatf("rnd%0d_hi", i), bus.hi, ehi);
      chk($sformatf("rnd%0d_lo", i), bus.lo, elo);
      if (lat != 33) chk($sformatf("rnd%0d_lat", i), lat, 33);
    end

    // MTHI / MTLO in idle
    bus.hi_we = 1; bus.wd = 32'h1234;
    @(posedge clk); #1 bus.hi_we = 0; bus.lo_we = 1; bus.wd = 32'h5678;
    @(posedge clk); #1 bus.lo_we = 0;
    chk("mthi", bus.hi, 32'h1234);
    chk("mtlo", bus.lo, 32'h5678);

    // start together with abort in idle is dropped
    bus.start = 1; bus.abort = 1; bus.op_div = 0; bus.op_signed = 0; bus.a = 6; bus.b = 7;
    @(posedge clk); #1 bus.start = 0; bus.abort = 0;
    chk("start_abort_idle_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("start_abort_idle_busy2", bus.busy, 0);

    // abort on the 10th busy cycle
    bus.start = 1;
    @(posedge clk); #1 bus.start = 0;
    repeat (9) begin @(posedge clk); #1; end
    chk("abort_pre_busy", bus.busy, 1);
    bus.abort = 1;
    @(posedge clk); #1 bus.abort = 0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.done || bus.busy) dcnt++; end
    chk("abort_no_done_later", dcnt, 0);
    chk("abort_hi", bus.hi, 32'h1234);
    chk("abort_lo", bus.lo, 32'h5678);

    // start and MTHI while busy are ignored
    bus.start = 1; bus.op_div = 0; bus.op_signed = 0; bus.a = 6; bus.b = 7;
    @(posedge clk); #1 bus.start = 0;
    repeat (3) begin @(posedge clk); #1; end
    bus.start = 1; bus.a = 9; bus.b = 9; bus.hi_we = 1; bus.wd = 32'hDEAD;
    @(posedge clk); #1 bus.start = 0; bus.hi_we = 0;
    chk("busy_mthi_hi", bus.hi, 32'h1234);
    lat = 99;
    for (int n = 5; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin lat = n; break; end
    end
    chk("t5_lat", lat, 33);
    chk("t5_hi", bus.hi, 0);
    chk("t5_lo", bus.lo, 42);

    // back-to-back start on the done cycle
    run_op(0, 0, 32'd2, 32'd5, lat, bcnt);
    chk("b2b_lat", lat, 33);
    chk("b2b_lo", bus.lo, 10);

    // async reset mid-calculation
    run_op(0, 0, 32'hFFFF_FFFF, 32'd2, lat, bcnt);
    chk("pre_rst_hi", bus.hi, 1);
    bus.start = 1; bus.a = 2; bus.b = 3;
    @(posedge clk); #1 bus.start = 0;
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("rst_mid_hi", bus.hi, 0);
    chk("rst_mid_lo", bus.lo, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    #2 rst = 0;
    @(posedge clk); #1;
    run_op(0, 0, 32'd2, 32'd3, lat, bcnt);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_hi", bus.hi, 0);
    chk("post_rst_lo", bus.lo, 6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
